// File: rtl/obstacle_spawn_sched_if.sv
// Gap-counter and renderer handshake bundle for the obstacle spawn scheduler.
// master = scheduler side, slave = counter/renderer side.
interface obstacle_spawn_sched_if #(
  parameter int BITS = 9
);
  logic [BITS-1:0] cnt_val;
  logic            cnt_load;
  logic [BITS-1:0] cnt_data;
  logic            spawn_valid;
  logic            spawn_ready;
  logic [1:0]      spawn_type;

  modport master (
    input  cnt_val,
    input  spawn_ready,
    output cnt_load,
    output cnt_data,
    output spawn_valid,
    output spawn_type
  );

  modport slave (
    output cnt_val,
    output spawn_ready,
    input  cnt_load,
    input  cnt_data,
    input  spawn_valid,
    input  spawn_type
  );
endinterface

// File: rtl/obstacle_spawn_sched.sv
// Dino-game obstacle spawn scheduler: LFSR gap, counter load, spawn handshake.
// SPAWN_BIRD_EN defined lets type 11 (bird) through; otherwise it maps to 10.
module obstacle_spawn_sched #(
  parameter int          BITS    = 9,
  parameter int          MIN_GAP = 64,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_run,
  input  logic [1:0]            speed,
  obstacle_spawn_sched_if.master bus,
  output logic [7:0]            spawn_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    COUNT,
    SPAWN
  } state_t;

  localparam logic [BITS:0] MIN_W = (BITS+1)'(MIN_GAP);

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            zero_q;
  logic            cnt_load_q;
  logic [BITS-1:0] cnt_data_q;
  logic            spawn_valid_q;
  logic [1:0]      type_q, type_d;
  logic [7:0]      count_q;
  logic [BITS:0]   rnd;
  logic [BITS:0]   sum;
  logic [BITS-1:0] gap;
  logic            accept;

  // Gap, LFSR step and type mapping from the current LFSR value
  always_comb begin
    rnd    = {2'b00, lfsr_q[BITS-2:0]} >> speed;
    sum    = MIN_W + rnd;
    gap    = sum[BITS] ? '1 : sum[BITS-1:0];
    lfsr_d = {1'b0, lfsr_q[15:1]}
           ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef SPAWN_BIRD_EN
    type_d = lfsr_q[15:14];
`else
    type_d = (lfsr_q[15:14] == 2'b11) ? 2'b10
                                      : lfsr_q[15:14];
`endif
    accept = (state_q == SPAWN) && spawn_valid_q
           && bus.spawn_ready;
  end

  // Next-state logic; dropping game_run always idles
  always_comb begin
    state_d = state_q;
    if (!game_run) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = LOAD;
        LOAD:    state_d = WAIT;
        WAIT:    state_d = COUNT;
        COUNT:   if (zero_q) state_d = SPAWN;
        SPAWN:   if (accept) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and registered zero sample of the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q  <= (bus.cnt_val == '0);
    end
  end

  // LFSR advances once per load, never reseeded outside reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (state_q == LOAD) begin
      lfsr_q <= lfsr_d;
    end
  end

  // Outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_load_q    <= 1'b0;
      cnt_data_q    <= '0;
      spawn_valid_q <= 1'b0;
      type_q        <= 2'b00;
    end else begin
      cnt_load_q    <= (state_d == LOAD);
      spawn_valid_q <= (state_d == SPAWN);
      if (state_d == LOAD) begin
        cnt_data_q <= gap;
        type_q     <= type_d;
      end
    end
  end

  // Accepted-obstacle counter, cleared on game start, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (state_q == IDLE && state_d == LOAD) begin
      count_q <= 8'd0;
    end else if (accept && state_d == LOAD
                 && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign bus.cnt_load    = cnt_load_q;
  assign bus.cnt_data    = cnt_data_q;
  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_type  = type_q;
  assign spawn_count     = count_q;

endmodule

// File: tb/tb_obstacle_spawn_sched.sv
// Directed bench for obstacle_spawn_sched with a gap down-counter model.
// Expected values are hand-computed from the LFSR sequence ACE1,E270,7138,...
module tb_obstacle_spawn_sched;

  logic       clk;
  logic       rst;
  logic       game_run;
  logic [1:0] speed;
  logic [7:0] spawn_count;
  logic [7:0] spawn_count2;
  logic [8:0] cnt_q;

  int n_tot;
  int n_bad;
  int cyc;
  int nseen;

`ifdef SPAWN_BIRD_EN
  localparam logic [1:0] T2 = 2'b11;
`else
  localparam logic [1:0] T2 = 2'b10;
`endif

  obstacle_spawn_sched_if #(.BITS(9)) sif ();
  obstacle_spawn_sched_if #(.BITS(9)) sif2 ();

  obstacle_spawn_sched #(
    .BITS(9),
    .MIN_GAP(64),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_run(game_run),
    .speed(speed),
    .bus(sif.master),
    .spawn_count(spawn_count)
  );

  obstacle_spawn_sched #(
    .BITS(9),
    .MIN_GAP(400),
    .SEED(16'hACE1)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .game_run(game_run),
    .speed(speed),
    .bus(sif2.master),
    .spawn_count(spawn_count2)
  );

  assign sif2.cnt_val     = 9'h1FF;
  assign sif2.spawn_ready = 1'b0;
  assign sif.cnt_val      = cnt_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gap down counter: load wins, otherwise count to zero and hold
  always @(posedge clk) begin
    if (rst) cnt_q <= 9'd0;
    else if (sif.cnt_load) cnt_q <= sif.cnt_data;
    else if (cnt_q != 9'd0) cnt_q <= cnt_q - 9'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int c);
    c = 0;
    while (!sif.spawn_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst = 1'b1;
    game_run = 1'b0;
    speed = 2'd0;
    sif.spawn_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load", sif.cnt_load, 0);
    chk("rst_data", sif.cnt_data, 0);
    chk("rst_valid", sif.spawn_valid, 0);
    chk("rst_type", sif.spawn_type, 0);
    chk("rst_count", spawn_count, 0);
    chk("rst_lfsr", dut.lfsr_q, 32'hACE1);
    chk("rst_state", dut.state_q, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_load", sif.cnt_load, 0);

    // first load, speed 0
    game_run = 1'b1;
    sif.spawn_ready = 1'b1;
    @(negedge clk);
    chk("ld1", sif.cnt_load, 1);
    chk("ld1_data", sif.cnt_data, 289);
    chk("ld1_type", sif.spawn_type, 2);
    chk("sat_data", sif2.cnt_data, 511);
    wait_valid(600, cyc);
    chk("lat1", cyc, 292);
    chk("lfsr1", dut.lfsr_q, 32'hE270);
    @(negedge clk);
    chk("v1_one", sif.spawn_valid, 0);
    chk("ld2", sif.cnt_load, 1);
    chk("ld2_data", sif.cnt_data, 176);
    chk("ld2_type", sif.spawn_type, T2);
    chk("cnt1", spawn_count, 1);

    // backpressure for 20 cycles
    sif.spawn_ready = 1'b0;
    wait_valid(600, cyc);
    chk("lat2", cyc, 179);
    for (int i = 0; i < 20; i++) begin
      chk("hold_v", sif.spawn_valid, 1);
      chk("hold_t", sif.spawn_type, T2);
      chk("hold_c", spawn_count, 1);
      @(negedge clk);
    end
    chk("hold_end", sif.spawn_valid, 1);
    sif.spawn_ready = 1'b1;
    @(negedge clk);
    sif.spawn_ready = 1'b0;
    chk("cnt2", spawn_count, 2);
    chk("acc_v", sif.spawn_valid, 0);
    chk("ld3", sif.cnt_load, 1);
    chk("ld3_data", sif.cnt_data, 120);
    chk("ld3_type", sif.spawn_type, 1);

    // abort in COUNT
    repeat (50) @(negedge clk);
    chk("in_count", dut.state_q, 3);
    game_run = 1'b0;
    @(negedge clk);
    chk("abC_state", dut.state_q, 0);
    chk("abC_load", sif.cnt_load, 0);
    chk("abC_valid", sif.spawn_valid, 0);
    chk("abC_count", spawn_count, 2);
    repeat (5) @(negedge clk);
    chk("abC_lfsr", dut.lfsr_q, 32'h389C);
    game_run = 1'b1;
    @(negedge clk);
    chk("ld4", sif.cnt_load, 1);
    chk("ld4_count", spawn_count, 0);
    chk("ld4_data", sif.cnt_data, 220);
    chk("ld4_type", sif.spawn_type, 0);

    // abort in SPAWN
    wait_valid(600, cyc);
    chk("lat4", cyc, 223);
    game_run = 1'b0;
    @(negedge clk);
    chk("abS_state", dut.state_q, 0);
    chk("abS_valid", sif.spawn_valid, 0);
    chk("abS_count", spawn_count, 0);
    chk("abS_lfsr", dut.lfsr_q, 32'h1C4E);

    // reset wins over game_run, then speed 3
    rst = 1'b1;
    game_run = 1'b1;
    speed = 2'd3;
    repeat (2) @(negedge clk);
    chk("rw_load", sif.cnt_load, 0);
    chk("rw_state", dut.state_q, 0);
    chk("rw_lfsr", dut.lfsr_q, 32'hACE1);
    rst = 1'b0;
    @(negedge clk);
    chk("sp3_load", sif.cnt_load, 1);
    chk("sp3_data", sif.cnt_data, 92);

    // saturation of the accepted counter
    sif.spawn_ready = 1'b1;
    nseen = 0;
    for (int c = 0; c < 40000 && nseen < 260; c++) begin
      @(negedge clk);
      if (sif.spawn_valid) nseen++;
    end
    chk("nspawn", nseen, 260);
    @(negedge clk);
    chk("cnt_sat", spawn_count, 255);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/obstacle_spawn_sched.md
# obstacle_spawn_sched

Schedules obstacle spawns for the dino game by driving the load port of the 9-bit obstacle-gap down counter and watching its count value. On each spawn it picks a pseudo-random gap from an internal LFSR, scaled by game speed. It then waits for the counter to reach zero and hands an obstacle type to the obstacle renderer over a valid/ready handshake.

## Interface
- `BITS`, 9: width of the gap counter value and load data.
- `MIN_GAP`, 64: minimum gap in clocks; must be ≥ 1 and < 2^BITS.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_run`  in  1  high while the game is running; low aborts and idles.
- `speed`  in  2  speed level 0–3; a higher level shortens the random part of the gap.
- `cnt_val`  in  BITS  current value of the down counter.
- `cnt_load`  out  1  one-cycle load strobe to the counter.
- `cnt_data`  out  BITS  gap value to load.
- `spawn_valid`  out  1  obstacle pending.
- `spawn_ready`  in  1  renderer accepts the obstacle.
- `spawn_type`  out  2  obstacle type: 00/01 small cactus, 10 large cactus, 11 bird.
- `spawn_count`  out  8  obstacles accepted since the game started; saturating.

## Operation
- FSM states are IDLE, LOAD, WAIT, COUNT and SPAWN.
- IDLE: all strobes low. Go to LOAD when `game_run`=1; `spawn_count` clears on this transition.
- LOAD (1 cycle):
  - `cnt_load`=1 and `cnt_data`=gap.
  - `spawn_type` is registered from `lfsr[15:14]`.
  - The LFSR steps once.
  - Next state is WAIT.
- WAIT (1 cycle): ignores `cnt_val` while the counter takes the load. Next state is COUNT.
- COUNT: go to SPAWN in the cycle after `cnt_val`==0 is sampled.
- SPAWN:
  - `spawn_valid`=1 and `spawn_type` holds stable.
  - On `spawn_valid`&`spawn_ready`: `spawn_count`++ (saturates at 255), then go to LOAD.
- Gap arithmetic:
  - rand = `lfsr[BITS-2:0]`.
  - gap = `MIN_GAP` + (rand >> `speed`), computed in BITS+1 bits.
  - If the sum exceeds 2^BITS−1, gap saturates to all-ones.
- LFSR:
  - 16-bit Galois, right shift: next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
  - Steps only in LOAD.
  - Reset to `SEED`; not reseeded when `game_run` toggles.
- `game_run`=0 in any state sends the FSM to IDLE next cycle:
  - `spawn_valid` drops and a pending obstacle is discarded.
  - `spawn_count` holds its value.
- `speed` is sampled only in LOAD. A change takes effect at the next gap.

## Timing
- Reset values: FSM=IDLE, `cnt_load`=0, `cnt_data`=0, `spawn_valid`=0, `spawn_type`=0, `spawn_count`=0, lfsr=`SEED`.
- All outputs are registered.
- `game_run` rising edge to `cnt_load`=1: 1 cycle (IDLE→LOAD).
- `cnt_load` cycle to first `spawn_valid`=1: gap+3 cycles. The counter shows the gap one cycle after load, reaches 0 gap cycles later, and SPAWN is entered the cycle after zero is sampled.
- Handshake:
  - `spawn_valid` stays high until accepted.
  - With `spawn_ready` tied high, valid is high exactly one cycle.
  - Next `cnt_load` follows in the cycle after acceptance.
- `rst` wins over every other input in the same cycle.

## Configuration
- `SPAWN_BIRD_EN` defined: type 11 is emitted as a bird.
- `SPAWN_BIRD_EN` undefined: `lfsr[15:14]`=11 maps to 10 (large cactus), so `spawn_type` never equals 11. The LFSR sequence and gaps are unchanged.

## Test plan
- Reset, then `game_run`=1 with `speed`=0 and defaults → `cnt_data`=289 (64+0xE1); `spawn_type`=10; LFSR becomes 16'hE270.
- Same as above but `speed`=3 → `cnt_data`=92.
- Counter model connected, `spawn_ready`=1:
  - First `spawn_valid` arrives 292 cycles after `cnt_load`.
  - Second load has `cnt_data`=176.
  - Second `spawn_type`=11 with `SPAWN_BIRD_EN`, 10 without.
- `MIN_GAP`=400, first load → rand 225 would give 625, so `cnt_data` saturates to 511.
- Hold `spawn_ready`=0 for 20 cycles in SPAWN → `spawn_valid` and `spawn_type` are stable for all 20 cycles, `spawn_count` unchanged; it increments by 1 on the accepting cycle.
- Drop `game_run` mid-COUNT and mid-SPAWN → IDLE next cycle, `spawn_valid`=0, no count increment. Re-raise `game_run` → `spawn_count`=0, and LFSR continues from its current state, not `SEED`.
